// File: rtl/fetch_controller.sv
// Fetch sequencer for a 1-cycle-latency synchronous instruction memory.
// It pairs each returned word with its PC and buffers it in a 2-entry skid FIFO in front of decode.
module fetch_controller #(
    parameter int          ADDR_W   = 4,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_instr
);

    logic [31:0]       fetch_pc_reg;
    logic              inflight_reg;
    logic [31:0]       inflight_pc_reg;
    logic [1:0]        fifo_cnt_reg;
    logic [31:0]       fifo_pc_reg    [2];
    logic [DATA_W-1:0] fifo_instr_reg [2];

    logic [31:0] redirect_target;
    logic [1:0]  occ;
    logic [1:0]  wr_idx;
    logic        deq;
    logic        issue;
    logic        bypass_xfer;
    logic        pop;
    logic        push;

    assign redirect_target = redirect_pc & ~32'h3;
    assign imem_addr       = rst ? RESET_PC[ADDR_W+1:2] : fetch_pc_reg[ADDR_W+1:2];

    // FIFO head has priority; an empty FIFO exposes the in-flight word straight from memory.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (!rst && !redirect_valid) begin
            if (fifo_cnt_reg != 2'd0) begin
                out_valid = 1'b1;
                out_pc    = fifo_pc_reg[0];
                out_instr = fifo_instr_reg[0];
            end else if (inflight_reg) begin
                out_valid = 1'b1;
                out_pc    = inflight_pc_reg;
                out_instr = imem_instr;
            end
        end
    end

    assign occ         = fifo_cnt_reg + {1'b0, inflight_reg};
    assign deq         = out_valid & out_ready;
    assign bypass_xfer = deq & (fifo_cnt_reg == 2'd0);
    assign pop         = deq & (fifo_cnt_reg != 2'd0);
    assign push        = inflight_reg & ~bypass_xfer;
    assign wr_idx      = fifo_cnt_reg - {1'b0, pop};
    // Issuing only when post-dequeue occupancy is below 2 keeps FIFO plus in-flight within capacity.
    assign issue       = ~redirect_valid & ((occ - {1'b0, deq}) < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            fifo_cnt_reg    <= 2'd0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
            inflight_reg <= 1'b0;
            fifo_cnt_reg <= 2'd0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + 32'd4;
            end
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Shift on pop first; a push to the same slot in the same cycle overrides it.
    always_ff @(posedge clk) begin
        if (pop) begin
            fifo_pc_reg[0]    <= fifo_pc_reg[1];
            fifo_instr_reg[0] <= fifo_instr_reg[1];
        end
        if (push) begin
            fifo_pc_reg[wr_idx[0]]    <= inflight_pc_reg;
            fifo_instr_reg[wr_idx[0]] <= imem_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            assert (!(push && !pop && fifo_cnt_reg == 2'd2));
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios followed by random ready/redirect/reset traffic.
// Each cycle is checked against a program-order model of the expected instruction stream.
module tb_fetch_controller;

    localparam int          ADDR_W   = 4;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_instr;

    always #5 clk = ~clk;

    fetch_controller #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Preloaded memory: mem[i] = A0000000 + i, one cycle of read latency.
    always_ff @(posedge clk) begin
        imem_instr <= 32'hA000_0000 + 32'(imem_addr);
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          age    = 0;      // cycles since the last flush edge; 0 = target issue cycle
    logic [31:0] exp_pc = RESET_PC;
    logic        prev_stall = 1'b0;
    logic        exp_valid  = 1'b0;

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        logic [31:0] word;
        word = 32'(pc[ADDR_W+1:2]);
        return 32'hA000_0000 + word;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (model pc %h)", tag, obs, exp, exp_pc);
        end
    endtask

    task automatic check_cycle();
        logic [31:0] ahead;
        exp_valid = !rst && !redirect_valid && (age >= 1);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, instr_at(exp_pc));
        end
        ahead = exp_pc + 32'd8;
        if (rst) begin
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_imem_addr", 32'(imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
        end else if (age == 0) begin
            chk("imem_addr_issue", 32'(imem_addr), 32'(exp_pc[ADDR_W+1:2]));
        end else if (prev_stall) begin
            // A stalled pipe holds the shown word plus one more, so fetch sits two words ahead.
            chk("imem_addr_stall", 32'(imem_addr), 32'(ahead[ADDR_W+1:2]));
        end
    endtask

    task automatic update_model();
        if (rst) begin
            age        = 0;
            exp_pc     = RESET_PC;
            prev_stall = 1'b0;
        end else if (redirect_valid) begin
            age        = 0;
            exp_pc     = {redirect_pc[31:2], 2'b00};
            prev_stall = 1'b0;
        end else begin
            if (exp_valid && out_ready) begin
                exp_pc = exp_pc + 32'd4;
            end
            prev_stall = exp_valid && !out_ready;
            if (age < 1000) age++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        $display("cyc rst=%0b rdr=%0b rdy=%0b | valid=%0b pc=%h instr=%h addr=%0d", rst,
                 redirect_valid, out_ready, out_valid, out_pc, out_instr, imem_addr);
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        repeat (3) tick();

        // Release: issue RESET_PC, then stream pc 0, 4.
        rst = 1'b0;
        repeat (3) tick();

        // Stall while pc 8 is shown, then drain 8,12,16,20 back to back.
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (4) tick();

        // Redirect to 0x26 while stalled with a full FIFO.
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h26;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Back-to-back redirects, then a sequential run across the memory wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_pc    = 32'h34;
        tick();
        redirect_valid = 1'b0;
        repeat (12) tick();

        // Reset together with a redirect: reset wins.
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        repeat (4) tick();

        // Random traffic.
        for (int i = 0; i < 200; i++) begin
            out_ready      = ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
